fifo_fwft_bram: RTL and testbench

//  Single-clock first-word-fall-through FIFO whose storage is a dual-port block RAM.
//  The head word is visible on data_o whenever empty_o is low; pop_i consumes it.

---
 rtl/fifo_fwft_bram_pkg.sv | 22 ++
 rtl/fifo_dpram.sv | 54 +++++
 rtl/fifo_fwft_bram.sv | 110 +++++++++++
 tb/tb_fifo_fwft_bram.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_fwft_bram_pkg.sv
// ---------------------------------------------------------------------------
// fifo_fwft_bram_pkg
//   Shared helpers for the first-word-fall-through block-RAM FIFO.
//   clog2() sizes the pointers (clog2(DEPTH) bits) and the usage counter
//   (clog2(DEPTH)+1 bits) in both the top and the RAM wrapper.
// ---------------------------------------------------------------------------
package fifo_fwft_bram_pkg;

  // Ceiling log2 for elaboration-time sizing. clog2(1) = 0, clog2(2) = 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : fifo_fwft_bram_pkg

// File: rtl/fifo_dpram.sv
// ---------------------------------------------------------------------------
// fifo_dpram
//   Simple dual-port RAM that maps onto a block RAM primitive.
//   Port 0 is a synchronous read port with a registered output. Port 1 is a
//   synchronous write port. When both ports address the same word in the same
//   cycle, port 0 returns the old contents (read-first). The FIFO top adds its
//   own bypass for that case.
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset (clears the read register only)
//   en0    : port 0 read enable; o0 holds its value while low
//   addr0  : port 0 read address
//   o0     : port 0 registered read data
//   we1    : port 1 write enable
//   addr1  : port 1 write address
//   i1     : port 1 write data
// ---------------------------------------------------------------------------
module fifo_dpram
  import fifo_fwft_bram_pkg::*;
#(
  parameter int SZ = 2,
  parameter int DW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en0,
  input  logic [clog2(SZ)-1:0] addr0,
  output logic [DW-1:0]        o0,
  input  logic                 we1,
  input  logic [clog2(SZ)-1:0] addr1,
  input  logic [DW-1:0]        i1
);

  logic [DW-1:0] mem [SZ];

  // NOTE: the storage array has no reset so it can map onto a block RAM;
  // the FIFO never exposes a word that was not written first.
  always_ff @(posedge clk_i) begin
    if (we1) begin
      mem[addr1] <= i1;
    end
  end

  // NOTE: non-blocking assignments here and in the write block give
  // read-first behaviour, because the read samples mem before the write updates it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      o0 <= '0;
    end else if (en0) begin
      o0 <= mem[addr0];
    end
  end

endmodule : fifo_dpram

// File: rtl/fifo_fwft_bram.sv
// ---------------------------------------------------------------------------
// fifo_fwft_bram
//   Single-clock first-word-fall-through FIFO backed by fifo_dpram. The head
//   word sits on data_o whenever empty_o is low, and pop_i consumes it. It is
//   used as the write-posting buffer in front of pi1 slaves.
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   push_i  : enqueue data_i this cycle (ignored when full without a pop)
//   data_i  : word to enqueue
//   full_o  : usage_o == DEPTH
//   pop_i   : consume the head word (ignored when empty)
//   data_o  : head word, valid while empty_o == 0; holds last value otherwise
//   empty_o : usage_o == 0
//   usage_o : number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module fifo_fwft_bram
  import fifo_fwft_bram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  full_o,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] usage_o
);

  localparam int AW = clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]    usage_q, usage_d;
  logic             byp_q;
  logic [WIDTH-1:0] byp_data_q;

  logic             pop_acc, push_acc;
  logic [AW-1:0]    rd_next;
  logic             rd_en, collide;
  logic [WIDTH-1:0] ram_q;

  // Flags come straight from the usage register, so push_i and pop_i never
  // reach an output combinationally.
  assign empty_o = (usage_q == '0);
  assign full_o  = (usage_q == UW'(DEPTH));
  assign usage_o = usage_q;

  // NOTE: every signal driven here gets a value on every path, so no latches.
  always_comb begin
    pop_acc  = pop_i && !empty_o;
    push_acc = push_i && (!full_o || pop_acc);
    usage_d  = usage_q + UW'(push_acc) - UW'(pop_acc);
    wr_ptr_d = wr_ptr_q + AW'(push_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop_acc);
    // Prefetch the word that will be the head after this edge.
    rd_next  = rd_ptr_d;
    // With nothing left to show, skip the read so data_o keeps its last value.
    rd_en    = (usage_d != '0);
    // The RAM is read-first, so a write to the address being prefetched must
    // be forwarded from data_i. This covers a push into an empty FIFO and
    // push+pop at usage 1. When full, wr_ptr == rd_ptr != rd_ptr+1, so a
    // push+pop while full never takes the bypass.
    collide  = push_acc && (wr_ptr_q == rd_next);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usage_q    <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
      // The bypass select only changes when the RAM output register updates,
      // so both sides of the data_o mux hold together while empty.
      if (rd_en) begin
        byp_q <= collide;
        if (collide) begin
          byp_data_q <= data_i;
        end
      end
    end
  end

  fifo_dpram #(
    .SZ (DEPTH),
    .DW (WIDTH)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en0   (rd_en),
    .addr0 (rd_next),
    .o0    (ram_q),
    .we1   (push_acc),
    .addr1 (wr_ptr_q),
    .i1    (data_i)
  );

  assign data_o = byp_q ? byp_data_q : ram_q;

endmodule : fifo_fwft_bram

// File: tb/tb_fifo_fwft_bram.sv
// ---------------------------------------------------------------------------
// tb_fifo_fwft_bram
//   Directed, table-driven bench for fifo_fwft_bram with DEPTH=4, WIDTH=8.
//   Each table row gives one cycle's inputs and the state expected after the
//   rising edge. Hand-written sequences cover asynchronous reset in mid-stream
//   and an interleaved wrap-around run checked against a small queue model.
// ---------------------------------------------------------------------------
module tb_fifo_fwft_bram;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic [2:0]       usage;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_fwft_bram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .push_i  (push),
    .data_i  (din),
    .full_o  (full),
    .pop_i   (pop),
    .data_o  (dout),
    .empty_o (empty),
    .usage_o (usage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             push;
    logic [WIDTH-1:0] din;
    logic             pop;
    logic             exp_empty;
    logic             exp_full;
    logic [2:0]       exp_usage;
    logic             chk_data;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic ps, input logic [7:0] d, input logic pp,
                     input logic e, input logic f, input logic [2:0] u,
                     input logic cd, input logic [7:0] ed);
    vec_t v;
    v.name = name; v.push = ps; v.din = d; v.pop = pp;
    v.exp_empty = e; v.exp_full = f; v.exp_usage = u;
    v.chk_data = cd; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  // Drive one cycle away from the edge, then sample 1 time unit after it.
  task automatic cycle(input logic ps, input logic [7:0] d, input logic pp);
    @(negedge clk);
    push = ps;
    din  = d;
    pop  = pp;
    @(posedge clk);
    #1;
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] model[$];
    logic       pa, ua;

    // Fill/overflow/drain, FWFT, simultaneous, full push+pop (DEPTH=4).
    //   name         push din    pop  empty full usage chk data
    add("fill1",      1, 8'h11, 0,   0,    0,   3'd1, 1, 8'h11);
    add("fill2",      1, 8'h22, 0,   0,    0,   3'd2, 1, 8'h11);
    add("fill3",      1, 8'h33, 0,   0,    0,   3'd3, 1, 8'h11);
    add("fill4",      1, 8'h44, 0,   0,    1,   3'd4, 1, 8'h11);
    add("ovf_drop",   1, 8'h55, 0,   0,    1,   3'd4, 1, 8'h11);
    add("drain1",     0, 8'h00, 1,   0,    0,   3'd3, 1, 8'h22);
    add("drain2",     0, 8'h00, 1,   0,    0,   3'd2, 1, 8'h33);
    add("drain3",     0, 8'h00, 1,   0,    0,   3'd1, 1, 8'h44);
    add("drain4",     0, 8'h00, 1,   1,    0,   3'd0, 0, 8'h00);
    add("pop_empty",  0, 8'h00, 1,   1,    0,   3'd0, 0, 8'h00);
    add("fwft_a5",    1, 8'hA5, 0,   0,    0,   3'd1, 1, 8'hA5);
    add("swap_10",    1, 8'h10, 1,   0,    0,   3'd1, 1, 8'h10);
    add("swap_20",    1, 8'h20, 1,   0,    0,   3'd1, 1, 8'h20);
    add("pop_20",     0, 8'h00, 1,   1,    0,   3'd0, 0, 8'h00);
    add("f01",        1, 8'h01, 0,   0,    0,   3'd1, 1, 8'h01);
    add("f02",        1, 8'h02, 0,   0,    0,   3'd2, 1, 8'h01);
    add("f03",        1, 8'h03, 0,   0,    0,   3'd3, 1, 8'h01);
    add("f04",        1, 8'h04, 0,   0,    1,   3'd4, 1, 8'h01);
    add("full_pp",    1, 8'h05, 1,   0,    1,   3'd4, 1, 8'h02);
    add("fd1",        0, 8'h00, 1,   0,    0,   3'd3, 1, 8'h03);
    add("fd2",        0, 8'h00, 1,   0,    0,   3'd2, 1, 8'h04);
    add("fd3",        0, 8'h00, 1,   0,    0,   3'd1, 1, 8'h05);
    add("fd4",        0, 8'h00, 1,   1,    0,   3'd0, 0, 8'h00);

    do_reset();
    check("rst_usage", 32'(usage), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_data",  32'(dout),  32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      push = vecs[i].push;
      din  = vecs[i].din;
      pop  = vecs[i].pop;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_usage"}, 32'(usage), 32'(vecs[i].exp_usage));
      check({vecs[i].name, "_empty"}, 32'(empty), 32'(vecs[i].exp_empty));
      check({vecs[i].name, "_full"},  32'(full),  32'(vecs[i].exp_full));
      if (vecs[i].chk_data) begin
        check({vecs[i].name, "_data"}, 32'(dout), 32'(vecs[i].exp_data));
      end
    end
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;

    // Wrap-around: 3*DEPTH interleaved cycles with a counting pattern, then
    // extra pops so pops on empty are exercised too.
    for (int i = 0; i < 3 * DEPTH + 6; i++) begin
      logic       ps, pp;
      logic [7:0] d;
      ps = (i < 3 * DEPTH) && ((i % 3) != 2);
      pp = (i >= 3 * DEPTH) || ((i % 2) == 1);
      d  = 8'(8'h60 + i);
      pa = pp && (model.size() != 0);
      ua = ps && ((model.size() < DEPTH) || pa);
      @(negedge clk);
      push = ps;
      din  = d;
      pop  = pp;
      @(posedge clk);
      #1;
      if (pa) void'(model.pop_front());
      if (ua) model.push_back(d);
      check($sformatf("wrap%0d_usage", i), 32'(usage), 32'(model.size()));
      check($sformatf("wrap%0d_empty", i), 32'(empty), 32'(model.size() == 0));
      if (model.size() != 0) begin
        check($sformatf("wrap%0d_data", i), 32'(dout), 32'(model[0]));
      end
    end
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;

    // Asynchronous reset in mid-stream with two words stored.
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b1, 8'h88, 1'b0);
    check("pre_rst_usage", 32'(usage), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_usage", 32'(usage), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full",  32'(full),  32'd0);
    check("async_rst_data",  32'(dout),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h99, 1'b0);
    check("post_rst_usage", 32'(usage), 32'd1);
    check("post_rst_data",  32'(dout),  32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fifo_fwft_bram
